// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: funct3 codes,
// FSM state encoding and the latched request bundle.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic logic is_half(input logic [2:0] f3);
    return (f3 == F3_H) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the memory stage and the data memory.
// master: memory stage (issues requests), slave: data_mem_responder.
interface data_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_funct3,
    output req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3,
    input  req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for RV32I loads/stores (little-endian).
// In: funct3, is_write, addr_lo, old_word, wdata.
// Out: st_word (merged store), ld_data (extended load), bad.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_write,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] st_word,
  output logic [31:0] ld_data,
  output logic        bad
);

  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic        h_mis;

  assign ld_b  = old_word[{addr_lo, 3'b000} +: 8];
  assign ld_h  = addr_lo[1] ? old_word[31:16]
                            : old_word[15:0];
  assign h_mis = is_half(funct3) && addr_lo[0];

  always_comb begin
    st_word = old_word;
    ld_data = '0;
    bad     = 1'b0;
    unique case (funct3)
      F3_B: begin
        if (is_write)
          st_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
        else
          ld_data = {{24{ld_b[7]}}, ld_b};
      end
      F3_BU: begin
        if (is_write) bad = 1'b1;
        else ld_data = {24'd0, ld_b};
      end
      F3_H: begin
        if (h_mis) bad = 1'b1;
        else if (is_write)
          st_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
        else
          ld_data = {{16{ld_h[15]}}, ld_h};
      end
      F3_HU: begin
        if (h_mis || is_write) bad = 1'b1;
        else ld_data = {16'd0, ld_h};
      end
      F3_W: begin
        if (addr_lo != 2'b00) bad = 1'b1;
        else if (is_write) st_word = wdata;
        else ld_data = old_word;
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory with valid/ready request/response.
// Ports: clk, reset (sync, active-high), bus (slave modport).
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  mem_req_t    req_q, req_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH];

  logic [AW-1:0] widx;
  logic [31:0]   old_word;
  logic [31:0]   st_word;
  logic [31:0]   ld_data;
  logic          lane_bad;
  logic          oor;
  logic          mem_we;

  assign widx     = req_q.addr[AW+1:2];
  assign old_word = mem_q[widx];
  // Word index beyond the array is rejected before any access.
  assign oor = {2'b00, req_q.addr[31:2]} >= 32'(DEPTH);

  mem_lane_align u_align (
    .funct3   (req_q.funct3),
    .is_write (req_q.write),
    .addr_lo  (req_q.addr[1:0]),
    .old_word (old_word),
    .wdata    (req_q.wdata),
    .st_word  (st_word),
    .ld_data  (ld_data),
    .bad      (lane_bad)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          req_d.write  = bus.req_write;
          req_d.funct3 = bus.req_funct3;
          req_d.addr   = bus.req_addr;
          req_d.wdata  = bus.req_wdata;
          cnt_d        = 16'(WAIT_STATES);
          state_d      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          state_d = ST_RESP;
          if (oor || lane_bad) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            err_d   = 1'b0;
            rdata_d = req_q.write ? '0 : ld_data;
            mem_we  = req_q.write;
          end
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Reset clears storage and drops any store still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[widx] <= st_word;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder.
// Expected responses are queued at issue and checked on resp.
module tb_data_mem_responder;

  localparam int WS = 2;

  logic clk;
  logic reset;
  int   cyc;
  int   n_vec;
  int   n_err;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t sb[$];

  data_mem_responder_if bus ();

  data_mem_responder #(
    .DEPTH       (256),
    .WAIT_STATES (WS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
  endtask

  task automatic pop_chk(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      chk({tag, "_sb"}, 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      chk({tag, "_rd"}, bus.resp_rdata, x.d);
      chk({tag, "_er"}, {31'd0, bus.resp_err}, {31'd0, x.e});
    end
  endtask

  // Issue one request; returns with resp still pending.
  task automatic issue(input string tag, input logic w,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic [31:0] ed, input logic ee,
                       output bit ok);
    bit got;
    int acc;
    ok = 1'b0;
    @(negedge clk);
    drive(w, f3, a, wd);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.req_ready) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      chk({tag, "_acc"}, {31'd0, bus.req_ready}, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    sb.push_back('{d: ed, e: ee});
    acc = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (bus.resp_valid) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      chk({tag, "_to"}, {31'd0, bus.resp_valid}, 32'd1);
      void'(sb.pop_front());
      return;
    end
    chk({tag, "_lat"}, 32'(cyc - acc), 32'(WS + 2));
    ok = 1'b1;
  endtask

  task automatic xfer(input string tag, input logic w,
                      input logic [2:0] f3,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input logic [31:0] ed, input logic ee);
    bit ok;
    issue(tag, w, f3, a, wd, ed, ee, ok);
    if (ok) begin
      pop_chk(tag);
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
    end
  endtask

  initial begin
    bit ok;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rv", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_rd", bus.resp_rdata, 32'd0);
    chk("rst_er", {31'd0, bus.resp_err}, 32'd0);
    reset = 1'b0;

    // word store/load
    xfer("sw10", 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    xfer("lw10", 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    // sub-word loads
    xfer("lb13", 0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 0);
    xfer("lbu13", 0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 0);
    xfer("lh12", 0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 0);
    xfer("lhu10", 0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 0);
    // sub-word stores
    xfer("sb11", 1, 3'b000, 32'h11, 32'h123456AA, 32'h0, 0);
    xfer("lw10b", 0, 3'b010, 32'h10, 32'h0, 32'hDEADAAEF, 0);
    xfer("sh12", 1, 3'b001, 32'h12, 32'h7777, 32'h0, 0);
    xfer("lw10c", 0, 3'b010, 32'h10, 32'h0, 32'h7777AAEF, 0);
    // errors
    xfer("lw12e", 0, 3'b010, 32'h12, 32'h0, 32'h0, 1);
    xfer("sh13e", 1, 3'b001, 32'h13, 32'hFFFF, 32'h0, 1);
    xfer("lw10d", 0, 3'b010, 32'h10, 32'h0, 32'h7777AAEF, 0);
    xfer("lw400e", 0, 3'b010, 32'h400, 32'h0, 32'h0, 1);
    xfer("lf3e", 0, 3'b011, 32'h10, 32'h0, 32'h0, 1);
    xfer("sf3e", 1, 3'b100, 32'h10, 32'h1, 32'h0, 1);
    xfer("lw3fc", 0, 3'b010, 32'h3FC, 32'h0, 32'h0, 0);

    // backpressure in RESP with extra requests pulsed
    issue("bp", 0, 3'b010, 32'h10, 32'h0, 32'h7777AAEF, 0, ok);
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        drive(1, 3'b010, 32'h10, 32'h00000BAD);
        chk("bp_rv", {31'd0, bus.resp_valid}, 32'd1);
        chk("bp_rd", bus.resp_rdata, 32'h7777AAEF);
        chk("bp_er", {31'd0, bus.resp_err}, 32'd0);
        chk("bp_rdy", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
      end
      pop_chk("bp");
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      chk("bp_idle", {31'd0, bus.req_ready}, 32'd1);
      chk("bp_rv0", {31'd0, bus.resp_valid}, 32'd0);
      repeat (6) @(negedge clk);
      chk("bp_noacc", {31'd0, bus.resp_valid}, 32'd0);
    end
    xfer("lw10e", 0, 3'b010, 32'h10, 32'h0, 32'h7777AAEF, 0);

    // reset during BUSY of a store
    @(negedge clk);
    drive(1, 3'b010, 32'h20, 32'h55);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rb_busy", {31'd0, bus.req_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rb_rdy", {31'd0, bus.req_ready}, 32'd1);
    chk("rb_rv", {31'd0, bus.resp_valid}, 32'd0);
    xfer("lw20", 0, 3'b010, 32'h20, 32'h0, 32'h0, 0);
    xfer("lw10r", 0, 3'b010, 32'h10, 32'h0, 32'h0, 0);

    chk("sb_left", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Multi-cycle data-memory slave answering load/store requests issued by the datapath's memory stage. Replaces the zero-latency data memory with a valid/ready request/response handshake and a configurable wait-state count. Supports RV32I byte/half/word access (LB, LH, LW, LBU, LHU, SB, SH, SW), little-endian. Flags misaligned, out-of-range or illegal accesses in the response.

Parameters:
DEPTH, 256, number of 32-bit words in the storage array (word index = addr[31:2])
WAIT_STATES, 2, extra busy cycles per access (0 allowed)

Ports:
clk  in  1  system clock, all state changes on rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I funct3 of the load/store
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  response present
resp_ready  in  1  datapath consumes response
resp_rdata  out  32  load data after extension; 0 for stores and errors
resp_err  out  1  access rejected

Behaviour:
- Interface decided: one clock `clk`; `reset` is synchronous and active-high.
- Reset: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0, all DEPTH words cleared to 0.
- Reset mid-operation wins over everything. It aborts a latched request, and a pending store is not performed.
- FSM states: IDLE, BUSY and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1, latch write, funct3, addr and wdata; load counter with WAIT_STATES; go to BUSY.
- BUSY:
  - req_ready=0.
  - If counter!=0, decrement it.
  - If counter==0, check the access, perform it, register resp_rdata/resp_err, and go to RESP.
- RESP:
  - resp_valid=1.
  - resp_rdata and resp_err are held stable until resp_valid&&resp_ready; then go to IDLE.
  - req_valid is ignored while in BUSY or RESP.
- Latency: a request accepted in cycle N gives resp_valid high from cycle N+WAIT_STATES+2. The next request can be accepted in the cycle after the response handshake.
- Error conditions (resp_err=1, resp_rdata=0, no memory write):
  - halfword access (funct3 001/101) with addr[0]=1;
  - word access (010) with addr[1:0]!=0;
  - addr[31:2] >= DEPTH;
  - load with funct3 in {011,110,111};
  - store with funct3 not in {000,001,010}.
- Load data is taken from word addr[31:2]:
  - LB: byte lane addr[1:0], sign-extended.
  - LBU: same lane, zero-extended.
  - LH: half lane addr[1], sign-extended.
  - LHU: same lane, zero-extended.
  - LW: full word.
- Stores modify only the addressed lanes; the other bytes are preserved.
  - SB writes wdata[7:0] to lane addr[1:0].
  - SH writes wdata[15:0] to lane addr[1].
  - SW writes the full word.
- Stores return resp_rdata=0 and resp_err=0.
- Storage updates only on the BUSY→RESP edge. A load issued after a completed store sees the new data.

Decomposition:
- Shared package mem_pkg holds:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - the FSM state encoding (IDLE/BUSY/RESP).
- One combinational sub-module, mem_lane_align, does lane selection:
  - inputs funct3, addr[1:0], old word and wdata;
  - outputs merged store word, extended load data, and misalign/illegal flag.
- The top level keeps the FSM, counter, array and range check.

Test Plan:
1. WAIT_STATES=2: SW 0xDEADBEEF @0x10, then LW @0x10 -> rdata=0xDEADBEEF, err=0; for each request accepted in cycle N, resp_valid first high in cycle N+4.
2. After test 1: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
3. SB wdata=0x123456AA @0x11, then LW @0x10 -> 0xDEADAAEF; SH wdata=0x7777 @0x12, then LW @0x10 -> 0x7777AAEF.
4. Error cases, each -> err=1, rdata=0: LW @0x12; SH @0x13 (then LW @0x10 unchanged); LW @0x400 with DEPTH=256; load funct3=011.
5. Hold resp_ready=0 for 3 cycles in RESP while pulsing req_valid -> resp_valid, rdata and err stable, req_ready=0, extra request not accepted; resp_ready=1 -> IDLE next cycle.
6. Assert reset during BUSY of SW 0x55 @0x20 -> next cycle req_ready=1, resp_valid=0; subsequent LW @0x20 -> 0x00000000.
